clk_divider: RTL and testbench
==============================

CLK_DIVIDER -- requirements
Module: clk_divider

Interface
REQ-001 Parameter WIDTH, default 8, width of divide ratio and period counter.
REQ-002 Parameter DEFAULT_DIV, default 2, divide ratio loaded at reset; SHALL be within 2..2^WIDTH-1.
REQ-003 clk_in  input  1  single clock, the buffered clock from the clock_buffer stage; all flops on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 en  input  1  run request; high starts/keeps the divided clock, low requests a stop at the period end.
REQ-006 cfg_valid  input  1  new divide ratio offered.
REQ-007 cfg_div  input  WIDTH  offered divide ratio R, sampled when cfg_valid and cfg_ready are both high.
REQ-008 cfg_ready  output  1  high when the block can accept a ratio.
REQ-009 cfg_err  output  1  one-cycle pulse when an accepted cfg_div is 0 or 1.
REQ-010 clk_out  output  1  divided clock, driven directly by a flop.
REQ-011 tick  output  1  one-clk_in-cycle pulse marking the first cycle of each clk_out period.
REQ-012 running  output  1  high in states RUN and DRAIN.

Function
REQ-013 State machine SHALL have states IDLE, RUN and DRAIN.
REQ-014 Active ratio R and counter cnt SHALL be WIDTH bits; H = floor(R/2).
REQ-015 In RUN and DRAIN, each edge: cnt <= (cnt == R-1) ? 0 : cnt+1; clk_out <= (next cnt < H); tick <= (next cnt == 0).
REQ-016 Each clk_out period SHALL be exactly R clk_in cycles: high H cycles, then low R-H cycles.
REQ-017 IDLE with en high: next edge enters RUN with cnt=0, clk_out=1 and tick=1; first rising edge of clk_out is one cycle after en is sampled high.
REQ-018 IDLE holds cnt=0, clk_out=0 and tick=0.
REQ-019 RUN with en low: go to DRAIN and continue counting.
REQ-020 DRAIN with en high: return to RUN with no change to cnt, clk_out or the period.
REQ-021 DRAIN at cnt == R-1 with en low: go to IDLE; clk_out low, no truncated high phase.
REQ-022 Handshake: a ratio is accepted on an edge where cfg_valid and cfg_ready are both high.
REQ-023 An accepted ratio of 0 or 1 SHALL be discarded, pulse cfg_err for one cycle and leave R unchanged.
REQ-024 An accepted valid ratio SHALL be held as pending and cfg_ready SHALL be low while a ratio is pending.
REQ-025 Pending ratio SHALL load into R on the wrap edge (cnt == R-1 to 0) in RUN/DRAIN, or on the next edge in IDLE, then clear pending.
REQ-026 The period starting at that wrap SHALL already use the new R; no period SHALL mix two ratios.
REQ-027 If a wrap and en falling coincide, the new R SHALL still load before DRAIN continues.
REQ-028 If a load in IDLE coincides with an en rise, the first period SHALL use the new R.
REQ-029 cfg_ready SHALL return high the cycle after pending clears.

Reset
REQ-030 rst_n low SHALL asynchronously force: state IDLE, R=DEFAULT_DIV, pending cleared, cnt=0, clk_out=0, tick=0, cfg_err=0, running=0, cfg_ready=1.
REQ-031 Reset asserted mid-period SHALL drop clk_out immediately, with no completion of the period.
REQ-032 After rst_n deasserts, the block SHALL start only on the first edge that samples en high.

Verification
REQ-033 Reset, en=1, default R=2 -> clk_out toggles every cycle: 1,0,1,0; tick high on each high cycle; running=1.
REQ-034 Load R=5 while in IDLE, then en=1 -> clk_out pattern 1,1,0,0,0 repeating; tick every 5th cycle.
REQ-035 Running at R=4, load R=7 mid-period -> cfg_ready low until the wrap; current period completes 4 cycles, the next is 7 cycles (3 high, 4 low); no glitch.
REQ-036 R=6, drop en at cnt=1 -> period completes (3 high, 3 low), then IDLE with clk_out=0 and running=0; re-raising en at cnt=3 in DRAIN instead continues periods unbroken.
REQ-037 Offer cfg_div=1, then cfg_div=0 -> cfg_err pulses once per offer; R and the clk_out period are unchanged.
REQ-038 Assert rst_n low during the clk_out high phase -> clk_out=0 and running=0 asynchronously; after release R=DEFAULT_DIV.

Source files
------------

// File: rtl/clk_divider.sv
// Programmable integer clock divider with a run/drain/idle controller and a ratio handshake.
// Ratio changes only take effect at a period boundary, so clk_out never carries a mixed period.
module clk_divider #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ratio, ratio_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] pend_div, pend_div_nxt;
    logic             pend, pend_nxt;
    logic             clk_nxt, tick_nxt, err_nxt;
    logic             accept, wrap;

    function automatic logic [WIDTH-1:0] half_of(input logic [WIDTH-1:0] r);
        return r >> 1;
    endfunction

    function automatic logic is_bad_ratio(input logic [WIDTH-1:0] r);
        return r < TWO;
    endfunction

    assign cfg_ready = !pend;
    assign running   = (state != IDLE);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ratio_nxt    = ratio;
        cnt_nxt      = cnt;
        clk_nxt      = clk_out;
        tick_nxt     = 1'b0;
        pend_nxt     = pend;
        pend_div_nxt = pend_div;
        err_nxt      = 1'b0;
        accept       = cfg_valid && !pend;
        wrap         = (cnt == ratio - ONE);

        // Accept and pending-load are mutually exclusive: acceptance needs pend low.
        if (accept) begin
            if (is_bad_ratio(cfg_div)) begin
                err_nxt = 1'b1;
            end else begin
                pend_nxt     = 1'b1;
                pend_div_nxt = cfg_div;
            end
        end

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                clk_nxt = 1'b0;
                if (pend) begin
                    ratio_nxt = pend_div;
                    pend_nxt  = 1'b0;
                end
                if (en) begin
                    state_nxt = RUN;
                    clk_nxt   = (half_of(ratio_nxt) != '0);
                    tick_nxt  = 1'b1;
                end
            end
            RUN, DRAIN: begin
                state_nxt = en ? RUN : DRAIN;
                if (wrap) begin
                    cnt_nxt = '0;
                    if (pend) begin
                        ratio_nxt = pend_div;
                        pend_nxt  = 1'b0;
                    end
                    if (state == DRAIN && !en) begin
                        state_nxt = IDLE;
                        clk_nxt   = 1'b0;
                    end else begin
                        clk_nxt  = (half_of(ratio_nxt) != '0);
                        tick_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + ONE;
                    clk_nxt = (cnt_nxt < half_of(ratio));
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                clk_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ratio    <= RST_DIV;
            cnt      <= '0;
            pend     <= 1'b0;
            pend_div <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            ratio    <= ratio_nxt;
            cnt      <= cnt_nxt;
            pend     <= pend_nxt;
            pend_div <= pend_div_nxt;
            clk_out  <= clk_nxt;
            tick     <= tick_nxt;
            cfg_err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_clk_divider.sv
// Scoreboard bench for clk_divider: a period-level reference model queues expected outputs,
// and a monitor compares them against the DUT one cycle at a time.
module tb_clk_divider;

    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 2;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             en;
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clk_out;
    logic             tick;
    logic             running;

    clk_divider #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_ready(cfg_ready),
        .cfg_err  (cfg_err),
        .clk_out  (clk_out),
        .tick     (tick),
        .running  (running)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic clk;
        logic tck;
        logic run;
        logic rdy;
        logic err;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_cyc   = 0;

    // Reference model: the active period is a queue of clk_out levels (H ones, then R-H zeros).
    int   m_R;
    int   m_pdiv;
    bit   m_active;
    bit   m_pend;
    bit   m_en_prev;
    bit   m_last_clk;
    bit   wave[$];

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (cycle %0d, t=%0t)", name, act, exp, n_cyc, $time);
        end
    endtask

    task automatic model_reset();
        m_R        = DEFAULT_DIV;
        m_pdiv     = 0;
        m_active   = 1'b0;
        m_pend     = 1'b0;
        m_en_prev  = 1'b0;
        m_last_clk = 1'b0;
        wave.delete();
    endtask

    task automatic start_period();
        wave.delete();
        for (int i = 0; i < m_R; i++) wave.push_back(i < m_R / 2);
    endtask

    task automatic step(input bit e, input bit cv, input int cd);
        exp_t x;
        bit   rdy;
        @(negedge clk_in);
        rst_n     = 1'b1;
        en        = e;
        cfg_valid = cv;
        cfg_div   = cd[WIDTH-1:0];
        rdy       = !m_pend;
        x         = '0;
        if (!m_active) begin
            if (m_pend) begin
                m_R    = m_pdiv;
                m_pend = 1'b0;
            end
            if (e) begin
                m_active = 1'b1;
                start_period();
                x.clk = wave.pop_front();
                x.tck = 1'b1;
            end
        end else if (wave.size() == 0) begin
            if (m_pend) begin
                m_R    = m_pdiv;
                m_pend = 1'b0;
            end
            if (!e && !m_en_prev) begin
                m_active = 1'b0;
            end else begin
                start_period();
                x.clk = wave.pop_front();
                x.tck = 1'b1;
            end
        end else begin
            x.clk = wave.pop_front();
        end
        m_en_prev = e;
        if (cv && rdy) begin
            if (cd < 2) begin
                x.err = 1'b1;
            end else begin
                m_pend = 1'b1;
                m_pdiv = cd;
            end
        end
        x.run      = m_active;
        x.rdy      = !m_pend;
        m_last_clk = x.clk;
        q.push_back(x);
    endtask

    task automatic reset_step(input bit e);
        exp_t x;
        @(negedge clk_in);
        rst_n     = 1'b0;
        en        = e;
        cfg_valid = 1'b0;
        x         = '0;
        x.rdy     = 1'b1;
        q.push_back(x);
    endtask

    always @(posedge clk_in) begin
        exp_t x;
        #1;
        n_cyc++;
        if (q.size() > 0) begin
            x = q.pop_front();
            check("clk_out",   clk_out,   x.clk);
            check("tick",      tick,      x.tck);
            check("running",   running,   x.run);
            check("cfg_ready", cfg_ready, x.rdy);
            check("cfg_err",   cfg_err,   x.err);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit re;
        bit found;
        rst_n     = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_clk_out",   clk_out,   1'b0);
        check("reset_tick",      tick,      1'b0);
        check("reset_running",   running,   1'b0);
        check("reset_cfg_ready", cfg_ready, 1'b1);
        check("reset_cfg_err",   cfg_err,   1'b0);
        model_reset();
        reset_step(1'b1);
        reset_step(1'b1);

        // Default ratio 2, then stop.
        repeat (8) step(1'b1, 1'b0, 0);
        repeat (4) step(1'b0, 1'b0, 0);

        // Ratio 5 loaded in IDLE coinciding with the start.
        step(1'b0, 1'b1, 5);
        repeat (15) step(1'b1, 1'b0, 0);
        repeat (8) step(1'b0, 1'b0, 0);

        // Ratio 4 running, switch to 7 mid-period.
        step(1'b0, 1'b1, 4);
        step(1'b0, 1'b0, 0);
        repeat (6) step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 7);
        repeat (3) step(1'b1, 1'b1, 9);
        repeat (20) step(1'b1, 1'b0, 0);

        // Illegal ratios are rejected.
        step(1'b1, 1'b1, 1);
        repeat (2) step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 0);
        repeat (16) step(1'b1, 1'b0, 0);

        // Ratio 6: drain to IDLE, then drain interrupted by en.
        repeat (12) step(1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 6);
        repeat (2) step(1'b1, 1'b0, 0);
        repeat (8) step(1'b0, 1'b0, 0);
        repeat (3) step(1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        repeat (14) step(1'b1, 1'b0, 0);

        // Randomized run/drain/reconfigure traffic.
        re = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) re = !re;
            step(re, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 12)));
        end

        // Asynchronous reset during a clk_out high phase.
        step(1'b1, 1'b1, 8);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b1, 1'b0, 0);
            found = m_last_clk;
        end
        check("found_high_phase", found, 1'b1);
        @(posedge clk_in);
        #2;
        check("pre_reset_clk_out", clk_out, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_reset_clk_out", clk_out, 1'b0);
        check("async_reset_running", running, 1'b0);
        model_reset();
        reset_step(1'b1);
        reset_step(1'b1);
        repeat (8) step(1'b1, 1'b0, 0);
        repeat (4) step(1'b0, 1'b0, 0);

        @(posedge clk_in);
        #2;
        check("scoreboard_drained", (q.size() == 0), 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
